// File: rtl/bus8088_pkg.sv
// Shared types and constants for the 8088 bus model: bus-cycle states,
// the latched transfer request, and bus widths.
package bus8088_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;

  // Read data returned when a cycle is aborted by the wait-state timeout.
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 8'hFF;

  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    T1   = 6'b000010,
    T2   = 6'b000100,
    T3   = 6'b001000,
    TW   = 6'b010000,
    T4   = 6'b100000
  } bus_state_t;

  typedef struct packed {
    logic              we;
    logic              io;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // RD_n/WR_n/DEN_n are active from T2 until the cycle leaves T3/TW.
  function automatic logic strobe_phase(input bus_state_t s);
    return (s == T2) || (s == T3) || (s == TW);
  endfunction

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// Requester handshake plus 8088 bus pins seen by the bus-cycle sequencer.
// slave = sequencer view, master = requester/device view.
interface bus_cycle_ctrl_if import bus8088_pkg::*; ();

  // Requester side
  logic              req;
  logic              we;
  logic              io;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;

  // Bus side
  logic              ready;
  logic              ALE;
  logic              IOM;
  logic              cs;
  logic [ADDR_W-1:0] bus_addr;
  logic              RD_n;
  logic              WR_n;
  logic              DEN_n;
  logic [DATA_W-1:0] bus_dout;
  logic              bus_doe;
  logic [DATA_W-1:0] bus_din;

  modport slave (
    input  req, we, io, addr, wdata, ready, bus_din,
    output ack, rdata, err, busy,
    output ALE, IOM, cs, bus_addr, RD_n, WR_n, DEN_n, bus_dout, bus_doe
  );

  modport master (
    output req, we, io, addr, wdata, ready, bus_din,
    input  ack, rdata, err, busy,
    input  ALE, IOM, cs, bus_addr, RD_n, WR_n, DEN_n, bus_dout, bus_doe
  );

endinterface

// File: rtl/wait_timer.sv
// Wait-state counter: cleared in T3, counts Tw cycles, and flags the
// MAX_WAIT-th consecutive Tw so the sequencer can abort in that cycle.
module wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + CW'(1);
    end
  end

  // count holds (n-1) during the n-th Tw cycle.
  assign tc = (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 8088 bus-cycle sequencer: accepts one transfer in IDLE and runs
// T1-T2-T3-(Tw)*-T4, with a bounded wait-state timeout.
module bus_cycle_ctrl import bus8088_pkg::*; #(
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  bus_cycle_ctrl_if.slave  bus
);

  bus_state_t        state;
  bus_state_t        state_next;
  bus_req_t          lat;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic accept;
  logic capture;
  logic timeout;
  logic timer_clear;
  logic timer_en;
  logic timer_tc;
  logic strobe;

  wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .en    (timer_en),
    .tc    (timer_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal written here gets a default before the case, so no
  // branch leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    capture     = 1'b0;
    timeout     = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req) begin
          accept     = 1'b1;
          state_next = T1;
        end
      end
      T1: state_next = T2;
      T2: state_next = T3;
      T3: begin
        timer_clear = 1'b1;
        if (bus.ready) begin
          capture    = 1'b1;
          state_next = T4;
        end else begin
          state_next = TW;
        end
      end
      TW: begin
        timer_en = 1'b1;
        if (bus.ready) begin
          capture    = 1'b1;
          state_next = T4;
        end else if (timer_tc) begin
          timeout    = 1'b1;
          state_next = T4;
        end
      end
      T4:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are frozen at acceptance; later input changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        lat.we    <= bus.we;
        lat.io    <= bus.io;
        lat.addr  <= bus.addr;
        lat.wdata <= bus.wdata;
        err_q     <= 1'b0;
      end
      if (capture && !lat.we) begin
        rdata_q <= bus.bus_din;
      end
      if (timeout) begin
        err_q <= 1'b1;
        if (!lat.we) begin
          rdata_q <= TIMEOUT_DATA;
        end
      end
    end
  end

  // Bus strobes decode from state alone, so reset deasserts them at once.
  assign strobe       = strobe_phase(state);

  assign bus.ALE      = (state == T1);
  assign bus.RD_n     = !(strobe && !lat.we);
  assign bus.WR_n     = !(strobe && lat.we);
  assign bus.DEN_n    = !strobe;
  assign bus.bus_doe  = strobe && lat.we;
  assign bus.IOM      = lat.io;
  assign bus.cs       = lat.addr[ADDR_W-1];
  assign bus.bus_addr = lat.addr;
  assign bus.bus_dout = lat.wdata;

  assign bus.ack      = (state == T4);
  assign bus.busy     = (state != IDLE);
  assign bus.rdata    = rdata_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: each transfer's timeline is
// predicted from its ready-sample sequence and compared cycle by cycle.
module tb_bus_cycle_ctrl;
  import bus8088_pkg::*;

  localparam int MAX_WAIT = 15;
  localparam int PERIOD   = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  bus_cycle_ctrl_if bus ();

  bus_cycle_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks    = 0;
  int          failures  = 0;
  logic [7:0]  exp_rdata = 8'h00;
  time         ack_time  = 0;

  function automatic bus_req_t mk_req(input logic we, input logic io,
                                      input logic [19:0] addr, input logic [7:0] wdata);
    bus_req_t r;
    r.we = we; r.io = io; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  // Spec rule: the cycle ends at the first ready=1 sample among T3 and up to
  // MAX_WAIT Tw samples; with none, it times out after exactly MAX_WAIT Tw.
  function automatic void model_outcome(input bit pat[$], output int w, output bit to);
    bit found = 1'b0;
    w  = MAX_WAIT;
    to = 1'b1;
    for (int i = 0; i <= MAX_WAIT; i++) begin
      if (!found && i < pat.size() && pat[i]) begin
        found = 1'b1;
        w     = i;
        to    = 1'b0;
      end
    end
  endfunction

  task automatic start_req(input bus_req_t r);
    bus.req   = 1'b1;
    bus.we    = r.we;
    bus.io    = r.io;
    bus.addr  = r.addr;
    bus.wdata = r.wdata;
  endtask

  task automatic scramble_fields();
    bus.we    = 1'($urandom);
    bus.io    = 1'($urandom);
    bus.addr  = 20'($urandom);
    bus.wdata = 8'($urandom);
  endtask

  // Called at a negedge with the request already driven. Runs the transfer
  // through the following IDLE cycle, checking every cycle.
  task automatic do_xfer(input bus_req_t r, input int nwait, input bit force_to,
                         input logic [7:0] cap_din, input bit chain,
                         input bus_req_t nxt, input string name);
    bit         pat[$];
    int         w;
    bit         to;
    int         last;
    bit         strobe;
    logic [8:0] obs_v;
    logic [8:0] exp_v;
    logic       exp_err;

    for (int i = 0; i < nwait; i++) pat.push_back(1'b0);
    if (force_to) begin
      while (pat.size() <= MAX_WAIT) pat.push_back(1'b0);
    end else begin
      pat.push_back(1'b1);
    end
    model_outcome(pat, w, to);
    last = 4 + w;

    @(posedge clk);
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      if (c <= last) begin
        strobe = (c >= 2) && (c <= 3 + w);
        exp_v  = {c == 1, r.io, r.addr[19], !(strobe && !r.we), !(strobe && r.we),
                  !strobe, strobe && r.we, 1'b1, c == last};
      end else begin
        exp_v  = {1'b0, r.io, r.addr[19], 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      end
      if (c == last && !r.we) exp_rdata = to ? TIMEOUT_DATA : cap_din;
      exp_err = (c >= last) ? to : 1'b0;
      if (c == last && bus.ack) ack_time = $time;

      obs_v = {bus.ALE, bus.IOM, bus.cs, bus.RD_n, bus.WR_n, bus.DEN_n,
               bus.bus_doe, bus.busy, bus.ack};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL %s cyc%0d ctrl{ALE,IOM,cs,RD_n,WR_n,DEN_n,doe,busy,ack} got=%b exp=%b",
                 name, c, obs_v, exp_v);
      end
      checks++;
      if (bus.bus_addr !== r.addr) begin
        failures++;
        $display("FAIL %s cyc%0d bus_addr got=%h exp=%h", name, c, bus.bus_addr, r.addr);
      end
      checks++;
      if (bus.bus_dout !== r.wdata) begin
        failures++;
        $display("FAIL %s cyc%0d bus_dout got=%h exp=%h", name, c, bus.bus_dout, r.wdata);
      end
      checks++;
      if (bus.rdata !== exp_rdata) begin
        failures++;
        $display("FAIL %s cyc%0d rdata got=%h exp=%h", name, c, bus.rdata, exp_rdata);
      end
      checks++;
      if (bus.err !== exp_err) begin
        failures++;
        $display("FAIL %s cyc%0d err got=%b exp=%b", name, c, bus.err, exp_err);
      end

      // Drive inputs for this cycle; they are sampled at the next posedge.
      if (chain) begin
        if (c >= last) begin
          bus.we = nxt.we; bus.io = nxt.io; bus.addr = nxt.addr; bus.wdata = nxt.wdata;
        end else begin
          scramble_fields();
        end
      end else if (c <= last) begin
        bus.req = 1'b0;
        scramble_fields();
      end
      if (c >= 3 && (c - 3) < pat.size()) bus.ready = pat[c-3];
      else                                bus.ready = 1'($urandom);
      bus.bus_din = (c == 3 + w) ? cap_din : 8'($urandom);
    end
  endtask

  task automatic test_reset();
    logic [8:0] obs_v;
    bus.req = 1'b0; bus.we = 1'b0; bus.io = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.ready = 1'b1; bus.bus_din = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    obs_v = {bus.ALE, bus.IOM, bus.cs, bus.RD_n, bus.WR_n, bus.DEN_n,
             bus.bus_doe, bus.busy, bus.ack};
    checks++;
    if (obs_v !== 9'b000111000) begin
      failures++;
      $display("FAIL reset ctrl got=%b exp=%b", obs_v, 9'b000111000);
    end
    checks++;
    if ({bus.bus_addr, bus.bus_dout, bus.rdata, bus.err} !== 37'd0) begin
      failures++;
      $display("FAIL reset data addr=%h dout=%h rdata=%h err=%b exp all zero",
               bus.bus_addr, bus.bus_dout, bus.rdata, bus.err);
    end
    reset = 1'b1;
    exp_rdata = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_mem_read();
    bus_req_t r = mk_req(1'b0, 1'b0, 20'h00010, 8'h5A);
    start_req(r);
    do_xfer(r, 0, 1'b0, 8'hA5, 1'b0, r, "mem_read");
  endtask

  task automatic test_mem_write_upper();
    bus_req_t r = mk_req(1'b1, 1'b0, 20'h80004, 8'h3C);
    start_req(r);
    do_xfer(r, 0, 1'b0, 8'h77, 1'b0, r, "mem_write_hi");
  endtask

  task automatic test_io_wait3();
    bus_req_t r = mk_req(1'b0, 1'b1, 20'h003F8, 8'h00);
    start_req(r);
    do_xfer(r, 3, 1'b0, 8'hC3, 1'b0, r, "io_wait3");
  endtask

  task automatic test_timeout();
    bus_req_t r = mk_req(1'b0, 1'b0, 20'h12345, 8'h11);
    bus_req_t n = mk_req(1'b1, 1'b1, 20'h00060, 8'h99);
    start_req(r);
    do_xfer(r, 0, 1'b1, 8'h42, 1'b0, r, "timeout");
    start_req(n);
    do_xfer(n, 1, 1'b0, 8'h00, 1'b0, n, "after_timeout");
    r = mk_req(1'b0, 1'b0, 20'hF0000, 8'h00);
    start_req(r);
    do_xfer(r, MAX_WAIT, 1'b0, 8'h6D, 1'b0, r, "max_wait_ok");
  endtask

  task automatic test_reset_mid();
    logic [6:0] obs_v;
    bus_req_t   r = mk_req(1'b1, 1'b0, 20'h80123, 8'hE7);
    start_req(r);
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    scramble_fields();
    @(negedge clk);
    checks++;
    if ({bus.WR_n, bus.DEN_n, bus.bus_doe} !== 3'b001) begin
      failures++;
      $display("FAIL rst_mid T2 {WR_n,DEN_n,doe} got=%b exp=001",
               {bus.WR_n, bus.DEN_n, bus.bus_doe});
    end
    #2 reset = 1'b0;
    #1;
    obs_v = {bus.ALE, bus.RD_n, bus.WR_n, bus.DEN_n, bus.bus_doe, bus.busy, bus.ack};
    checks++;
    if (obs_v !== 7'b0111000) begin
      failures++;
      $display("FAIL rst_mid async {ALE,RD_n,WR_n,DEN_n,doe,busy,ack} got=%b exp=0111000",
               obs_v);
    end
    @(negedge clk);
    reset = 1'b1;
    exp_rdata = 8'h00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.ack} !== 2'b00) begin
        failures++;
        $display("FAIL rst_mid no_retry cyc%0d {busy,ack} got=%b exp=00", i, {bus.busy, bus.ack});
      end
    end
    r = mk_req(1'b1, 1'b0, 20'h00ABC, 8'h5E);
    start_req(r);
    do_xfer(r, 0, 1'b0, 8'h00, 1'b0, r, "after_reset");
  endtask

  task automatic test_back_to_back();
    bus_req_t a = mk_req(1'b0, 1'b0, 20'h01000, 8'h01);
    bus_req_t b = mk_req(1'b1, 1'b1, 20'h8FFFF, 8'hB2);
    time      t1;
    time      t2;
    start_req(a);
    ack_time = 0;
    do_xfer(a, 0, 1'b0, 8'h3E, 1'b1, b, "b2b_first");
    t1 = ack_time;
    ack_time = 0;
    do_xfer(b, 0, 1'b0, 8'h00, 1'b0, b, "b2b_second");
    t2 = ack_time;
    checks++;
    if (t1 == 0 || t2 - t1 != 5 * PERIOD) begin
      failures++;
      $display("FAIL b2b ack spacing got=%0t exp=%0d (t1=%0t t2=%0t)", t2 - t1, 5 * PERIOD, t1, t2);
    end
  endtask

  task automatic test_random();
    bus_req_t r;
    int       nw;
    bit       to;
    for (int i = 0; i < 20; i++) begin
      r  = mk_req(1'($urandom), 1'($urandom), 20'($urandom), 8'($urandom));
      to = ($urandom_range(0, 5) == 0);
      nw = to ? 0 : $urandom_range(0, MAX_WAIT);
      start_req(r);
      do_xfer(r, nw, to, 8'($urandom), 1'b0, r, "random");
    end
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_mem_write_upper();
    test_io_wait3();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_cycle_ctrl.md
# bus_cycle_ctrl

Bus-cycle sequencer for the 8088 bus model: accepts one memory or I/O transfer at a time over a simple req/ack handshake and drives the T1–T4 strobe sequence (ALE, IOM, RD_n, WR_n, DEN_n, cs, address, write data) that the memory/IO device model decodes. It inserts Tw wait states while `ready` is low and aborts with an error after a bounded wait. It sits between the testbench/CPU-side requester and the shared memory/IO bus.

## Interface

Parameters:
- `MAX_WAIT`, 15, maximum consecutive Tw states before a timeout abort (1..255)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  1  transfer request, held high until `ack`
- `we`  in  1  1 = write, 0 = read; sampled with `req`
- `io`  in  1  1 = I/O cycle, 0 = memory cycle; sampled with `req`
- `addr`  in  20  transfer address; sampled with `req`
- `wdata`  in  8  write data; sampled with `req`
- `ack`  out  1  one-cycle completion pulse
- `rdata`  out  8  read data, valid while `ack` is high and held until the next capture
- `err`  out  1  timeout flag, valid with `ack`
- `busy`  out  1  high from acceptance through T4
- `ready`  in  1  bus ready from the addressed device
- `ALE`  out  1  address latch enable, high in T1 only
- `IOM`  out  1  latched `io` for the whole cycle
- `cs`  out  1  bank select = latched `addr[19]`
- `bus_addr`  out  20  latched address
- `RD_n`  out  1  read strobe, low T2 through T3/Tw (read)
- `WR_n`  out  1  write strobe, low T2 through T3/Tw (write)
- `DEN_n`  out  1  data enable, low T2 through T3/Tw
- `bus_dout`  out  8  latched write data
- `bus_doe`  out  1  write-data output enable; the top level builds the tristate
- `bus_din`  in  8  read data from the bus

## Operation

- States: IDLE, T1, T2, T3, TW, T4.
- IDLE: when `req`=1, latch `we`, `io`, `addr`, `wdata`, then go to T1 and raise `busy`. Requests are accepted only in IDLE.
- T1: `ALE`=1. `IOM`, `cs` and `bus_addr` are valid. Go to T2.
- T2: assert `RD_n`=0 (read) or `WR_n`=0 with `bus_doe`=1 (write), and `DEN_n`=0. Go to T3.
- T3: strobes stay asserted.
  - `ready`=1: go to T4. On a read, capture `bus_din` into `rdata` on this edge.
  - `ready`=0: go to TW and clear the wait counter.
- TW: strobes stay asserted and the wait counter increments each cycle.
  - `ready`=1: go to T4 with the same capture rule as T3.
  - Counter reaches `MAX_WAIT` with `ready`=0: go to T4 with `err`=1. On a read, `rdata` is set to 8'hFF.
- T4: all strobes deasserted, `bus_doe`=0, `ack`=1, `busy`=0 at exit. Always returns to IDLE.
- `err` is cleared at acceptance of the next request.
- Address, IOM and cs are held through T4, then keep their values until the next acceptance.
- Input changes after acceptance have no effect on the cycle in progress.

## Timing

- Reset values: `ALE`=0, `RD_n`=`WR_n`=`DEN_n`=1, `IOM`=0, `cs`=0, `bus_addr`=0, `bus_dout`=0, `bus_doe`=0, `ack`=0, `rdata`=0, `err`=0, `busy`=0.
- All outputs are registered or decoded from state only. There is no combinational path from `req` or `ready` to any output.
- Zero-wait latency: `req` sampled at edge k puts T1 in cycle k+1 and `ack` in cycle k+4.
- Each Tw state adds one cycle.
- Minimum issue interval is 5 cycles. An IDLE cycle always separates consecutive transfers.
- `ready` is sampled only in T3 and TW.
- Timeout: exactly `MAX_WAIT` Tw cycles, then T4.
- Reset asserted mid-cycle: all strobes deassert immediately (asynchronous) and state returns to IDLE. No `ack` is produced, and the aborted request is not retried.
- `req`=1 during T4 or on the cycle after `ack` is treated as a new request once IDLE is reached. The requester must drop `req` on the cycle after `ack`.

## Structure

- Shared package `bus8088_pkg`:
  - `bus_state_t` enum (one-hot, matching the device-model style)
  - `bus_req_t` struct {we, io, addr, wdata}
  - `ADDR_W`=20, `DATA_W`=8
  - constant `TIMEOUT_DATA`=8'hFF
- Sub-module `wait_timer`: clear/enable counter with a terminal-count output, parameterised by `MAX_WAIT`.

## Test plan

- Memory read, zero wait: req, we=0, io=0, addr=20'h00010, `ready`=1, `bus_din`=8'hA5 -> ALE in cycle k+1, RD_n low in cycles k+2..k+3, `ack` and `rdata`=8'hA5 in cycle k+4, err=0.
- Memory write to the upper bank: addr=20'h80004, wdata=8'h3C -> cs=1, WR_n and bus_doe active for 2 cycles with bus_dout=8'h3C, RD_n stays 1.
- I/O read with 3 wait states: io=1, `ready` low for 3 T3/TW samples -> IOM=1, `ack` at cycle k+7, rdata captured on the edge where ready=1.
- Timeout: `ready` held 0 with MAX_WAIT=15 -> `ack` at cycle k+19, err=1, rdata=8'hFF. The next request clears err.
- Reset during T2 of a write -> WR_n, DEN_n, bus_doe return to inactive asynchronously, no ack, busy=0. A new request after reset release completes normally.
- Back-to-back: req held continuously across two transfers -> acks exactly 5 cycles apart, one IDLE cycle between them, second-transfer fields latched at its own acceptance.
